// File: rtl/decode_issue_stage_if.sv
// Fetch, issue, register-file read and writeback signals of the decode/issue stage.
// The bench (master) drives fetch/execute/writeback inputs; the stage (slave) drives the rest.
interface decode_issue_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic [REG_AW-1:0] rf_rs1;
  logic [REG_AW-1:0] rf_rs2;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [6:0]        out_opcode;
  logic [2:0]        out_funct3;
  logic [6:0]        out_funct7;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_imm;
  logic              out_writes_rd;
  logic              out_illegal;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              stall_hazard;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_opcode, out_funct3,
           out_funct7, out_rd, out_imm, out_writes_rd, out_illegal, stall_hazard
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_opcode, out_funct3,
           out_funct7, out_rd, out_imm, out_writes_rd, out_illegal, stall_hazard
  );
endinterface

// File: rtl/decode_issue_stage.sv
// Single-entry RV32I decode/issue stage with a register scoreboard.
// Holds one instruction and issues it once none of its operands or its rd is pending.
module decode_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic clk,
  input  logic reset,
  decode_issue_stage_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  logic              hold_valid;
  logic [31:0]       hold_instr;
  logic [XLEN-1:0]   hold_pc;
  logic [NREG-1:0]   sb;

  fmt_e              fmt;
  logic              uses_rs1, uses_rs2, writes_rd, illegal;
  logic [31:0]       imm32;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              hazard, issue, accept;

  assign rs1 = hold_instr[19:15];
  assign rs2 = hold_instr[24:20];
  assign rd  = hold_instr[11:7];

  always_comb begin
    fmt       = FMT_I;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (hold_instr[6:0])
      7'b0110111, 7'b0010111: begin fmt = FMT_U; writes_rd = 1'b1; end
      7'b1101111:             begin fmt = FMT_J; writes_rd = 1'b1; end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        fmt = FMT_I; uses_rs1 = 1'b1; writes_rd = 1'b1;
      end
      // FENCE/SYSTEM read rs1 like I-type but never commit a register write
      7'b0001111, 7'b1110011: begin fmt = FMT_I; uses_rs1 = 1'b1; end
      7'b0100011: begin fmt = FMT_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin fmt = FMT_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0110011: begin
        fmt = FMT_R; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (rd == '0) writes_rd = 1'b0;
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{hold_instr[31]}}, hold_instr[31:20]};
      FMT_S: imm32 = {{20{hold_instr[31]}}, hold_instr[31:25], hold_instr[11:7]};
      FMT_B: imm32 = {{19{hold_instr[31]}}, hold_instr[31], hold_instr[7],
                      hold_instr[30:25], hold_instr[11:8], 1'b0};
      FMT_U: imm32 = {hold_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{hold_instr[31]}}, hold_instr[31], hold_instr[19:12],
                      hold_instr[20], hold_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    if (illegal) imm32 = '0;
  end

  // x0 is masked explicitly so a stray scoreboard bit can never stall on it
  assign hazard = (uses_rs1  && rs1 != '0 && sb[rs1]) ||
                  (uses_rs2  && rs2 != '0 && sb[rs2]) ||
                  (writes_rd && sb[rd]);

  assign bus.stall_hazard  = reset & hold_valid & hazard;
  assign bus.out_valid     = reset & hold_valid & ~hazard & ~bus.flush;
  assign bus.in_ready      = reset & ~bus.flush & (~hold_valid | (bus.out_valid & bus.out_ready));
  assign issue             = bus.out_valid & bus.out_ready;
  assign accept            = bus.in_valid & bus.in_ready;

  assign bus.rf_rs1        = rs1;
  assign bus.rf_rs2        = rs2;
  assign bus.out_pc        = hold_pc;
  assign bus.out_opcode    = hold_instr[6:0];
  assign bus.out_funct3    = hold_instr[14:12];
  assign bus.out_funct7    = hold_instr[31:25];
  assign bus.out_rd        = rd;
  assign bus.out_imm       = XLEN'(signed'(imm32));
  assign bus.out_writes_rd = writes_rd;
  assign bus.out_illegal   = illegal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
      sb         <= '0;
    end else begin
      if (bus.flush)   hold_valid <= 1'b0;
      else if (accept) begin
        hold_valid <= 1'b1;
        hold_instr <= bus.in_instr;
        hold_pc    <= bus.in_pc;
      end else if (issue) hold_valid <= 1'b0;
      // set is applied after clear so a same-cycle set on the same register wins
      if (bus.wb_valid && bus.wb_rd != '0) sb[bus.wb_rd] <= 1'b0;
      if (issue && writes_rd)              sb[rd]        <= 1'b1;
    end
  end
endmodule
